draw_ball: RTL and testbench
============================

// Module: draw_ball
// PURPOSE
// - Pixel-stream stage downstream of the ball position controller: overlays a filled
//   circular puck at (xpos_ball, ypos_ball) on the incoming VGA timing/RGB stream.
// - Sits between the background/player draw stages and the VGA output register.
// - Ball position is sampled once per frame so the puck never tears mid-frame.
// PARAMETERS
// RADIUS_BALL   10      puck radius in pixels; must match the controller's value
// BALL_COLOR    12'hF00 RGB444 fill colour of the puck
// X_INIT        487     latched x position after reset (same as controller reset)
// Y_INIT        362     latched y position after reset
// PORTS
// clk_in     in   1   pixel clock
// rst_n      in   1   asynchronous, active-low reset
// xpos_ball  in   12  ball centre x from the ball controller (clk_in domain)
// ypos_ball  in   12  ball centre y from the ball controller
// hcount_in  in   12  horizontal pixel counter
// vcount_in  in   12  vertical pixel counter
// hsync_in   in   1   horizontal sync
// vsync_in   in   1   vertical sync
// hblnk_in   in   1   horizontal blanking
// vblnk_in   in   1   vertical blanking
// rgb_in     in   12  upstream pixel colour, RGB444
// hcount_out out  12  hcount_in delayed 3 cycles
// vcount_out out  12  vcount_in delayed 3 cycles
// hsync_out  out  1   hsync_in delayed 3 cycles
// vsync_out  out  1   vsync_in delayed 3 cycles
// hblnk_out  out  1   hblnk_in delayed 3 cycles
// vblnk_out  out  1   vblnk_in delayed 3 cycles
// rgb_out    out  12  rgb_in delayed 3 cycles, or BALL_COLOR inside the puck
// BEHAVIOUR
// - Reset (rst_n low, async assert, sync-released by clk_in): all outputs 0; all pipeline
//   registers 0; latched position = (X_INIT, Y_INIT); vblnk edge detector = 0.
// - Position latch: vblnk_d = vblnk_in registered. On the cycle where vblnk_in=1 and
//   vblnk_d=0 (rising edge), capture xpos_ball/ypos_ball into x_lat/y_lat. No other
//   update. The new value is first used by pixels entering stage 1 on the next cycle.
// - Pipeline, fixed latency 3 cycles, no stalls, one pixel per clock:
//   S1: dx = $signed({1'b0,hcount_in}) - $signed({1'b0,x_lat}) (13b signed); dy same
//       with vcount_in / y_lat.
//   S2: dx2 = dx*dx, dy2 = dy*dy (26b unsigned each).
//   S3: dist2 = dx2 + dy2 (27b). inside = (dist2 <= RADIUS_BALL*RADIUS_BALL) and
//       neither blank delayed to S3 is set. rgb_out = inside ? BALL_COLOR : rgb_in_d3.
// - All timing signals and rgb_in travel through 3 identical register stages so every
//   output belongs to the same pixel.
// - Edge of circle inclusive: dist2 == R^2 is drawn. Centre pixel always drawn.
// - Off-screen/partial puck: signed arithmetic, no clamping; pixels outside the visible
//   area are simply never produced. x_lat < RADIUS_BALL must not wrap or alias.
// - Blanking: during hblnk or vblnk rgb_out = rgb_in delayed (puck never drawn).
// - Reset mid-frame: outputs drop to 0 immediately; after release the first 3 outputs
//   are 0 (pipeline fill), then valid; latch holds X_INIT/Y_INIT until next vblnk edge.
// - xpos/ypos changing mid-frame: ignored until the next vblnk rising edge.
// STRUCTURE
// - Shared package vga_pkg: RGB444 width, timing-counter width (12), colour constants
//   (BALL_COLOR default), screen geometry constants.
// - One sub-module: delay (params WIDTH, CLK_DEL) carrying {hcount,vcount,hsync,vsync,
//   hblnk,vblnk,rgb} 3 cycles; arithmetic datapath and latch stay in draw_ball.
// - Multipliers: two 13x13 per cycle; expect DSP inference, registered in/out.
// TESTING
// - Reset: rst_n=0 mid-line -> all outputs 0 same cycle; release -> 3 cycles of 0, then
//   delayed stream; pixel (487,362) in first frame -> rgb_out=12'hF00.
// - Latency: drive hcount_in=100, vcount_in=50, rgb_in=12'h0A5 -> exactly 3 clocks later
//   hcount_out=100, vcount_out=50, rgb_out=12'h0A5; syncs/blanks likewise.
// - Circle boundary, ball latched at (500,400): (510,400) and (506,408) -> F00;
//   (511,400) and (508,407) -> rgb_in passthrough.
// - Frame latch: change xpos_ball 500->600 mid-frame -> rest of frame still centred at
//   500; after next vblnk rising edge, next frame centred at 600.
// - Screen edge: ball latched at (5,5) -> pixels (0,0) and (0,13) drawn F00, no wrap
//   artefacts at hcount=4090 area (fed with blanking) or right edge.
// - Blanking: hblnk_in=1 with hcount_in=500, vcount_in=400, ball at (500,400) ->
//   rgb_out = delayed rgb_in, not F00.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel/counter widths, default colours, screen geometry
// and the packed timing+colour bundle carried down the draw pipeline.
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int CNT_W = 12;

  localparam logic [RGB_W-1:0] BALL_COLOR_DEF = 12'hF00;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/delay.sv
// Fixed-latency register chain: dout is din delayed by CLK_DEL clocks.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  // NOTE: non-blocking assignments let every stage sample its predecessor's old
  // value, so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_ball.sv
// Overlays a filled circular puck on the VGA stream; ball position is latched once
// per frame on the vblnk rising edge and the stream is delayed by 3 clocks.
module draw_ball
  import vga_pkg::*;
#(
  parameter int               RADIUS_BALL = 10,
  parameter logic [RGB_W-1:0] BALL_COLOR  = BALL_COLOR_DEF,
  parameter int               X_INIT      = 487,
  parameter int               Y_INIT      = 362
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] xpos_ball,
  input  logic [CNT_W-1:0] ypos_ball,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);

  localparam logic [26:0] R2 = 27'(RADIUS_BALL * RADIUS_BALL);

  logic                    vblnk_d;
  logic [CNT_W-1:0]        x_lat, y_lat;
  logic signed [CNT_W:0]   dx, dy;
  logic signed [25:0]      dx_ext, dy_ext, dx_sq, dy_sq;
  logic [25:0]             dx2, dy2;
  logic [26:0]             dist2;
  logic                    vld1, vld2, in_circle;
  vga_bus_t                bus_in, bus_d3;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d <= 1'b0;
      x_lat   <= CNT_W'(X_INIT);
      y_lat   <= CNT_W'(Y_INIT);
    end else begin
      vblnk_d <= vblnk_in;
      if (vblnk_in && !vblnk_d) begin
        x_lat <= xpos_ball;
        y_lat <= ypos_ball;
      end
    end
  end

  // Zero-extend before subtracting so a ball near the left/top edge goes negative
  // instead of wrapping to a large unsigned distance.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dx   <= '0;
      dy   <= '0;
      vld1 <= 1'b0;
    end else begin
      dx   <= $signed({1'b0, hcount_in}) - $signed({1'b0, x_lat});
      dy   <= $signed({1'b0, vcount_in}) - $signed({1'b0, y_lat});
      vld1 <= 1'b1;
    end
  end

  always_comb begin
    dx_ext = 26'(dx);
    dy_ext = 26'(dy);
    dx_sq  = dx_ext * dx_ext;
    dy_sq  = dy_ext * dy_ext;
    dist2  = {1'b0, dx2} + {1'b0, dy2};
  end

  // The valid bits keep the all-zero reset contents (distance 0) from being drawn
  // while the pipeline refills.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dx2       <= '0;
      dy2       <= '0;
      vld2      <= 1'b0;
      in_circle <= 1'b0;
    end else begin
      dx2       <= unsigned'(dx_sq);
      dy2       <= unsigned'(dy_sq);
      vld2      <= vld1;
      in_circle <= vld2 && (dist2 <= R2);
    end
  end

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

  delay #(
    .WIDTH  ($bits(vga_bus_t)),
    .CLK_DEL(3)
  ) u_delay (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (bus_in),
    .dout   (bus_d3)
  );

  assign hcount_out = bus_d3.hcount;
  assign vcount_out = bus_d3.vcount;
  assign hsync_out  = bus_d3.hsync;
  assign vsync_out  = bus_d3.vsync;
  assign hblnk_out  = bus_d3.hblnk;
  assign vblnk_out  = bus_d3.vblnk;
  assign rgb_out    = (in_circle && !bus_d3.hblnk && !bus_d3.vblnk) ? BALL_COLOR : bus_d3.rgb;

endmodule

// File: tb/tb_draw_ball.sv
// Scoreboard bench for draw_ball: every driven pixel pushes its expected output
// bundle, which is popped and compared when it emerges three clocks later.
module tb_draw_ball;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] xpos_ball = '0, ypos_ball = '0;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

  always #5 clk_in = ~clk_in;

  draw_ball dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .xpos_ball  (xpos_ball),
    .ypos_ball  (ypos_ball),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: latched centre and previous vblnk as driven.
  int cx = 487, cy = 362;
  bit prev_vb = 1'b0;

  logic [39:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [39:0] out_bus();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
  endfunction

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit hb,
                                            input bit vb, input logic [11:0] rgb);
    int dxm, dym;
    dxm = h - cx;
    dym = v - cy;
    if (!hb && !vb && (dxm * dxm + dym * dym <= 100)) return 12'hF00;
    return rgb;
  endfunction

  task automatic step(input string tag, input int h, input int v, input bit hs,
                      input bit vs, input bit hb, input bit vb, input logic [11:0] rgb);
    logic [39:0] e;
    string       t;
    hcount_in = 12'(h);
    vcount_in = 12'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    e = {12'(h), 12'(v), hs, vs, hb, vb, model_rgb(h, v, hb, vb, rgb)};
    if (vb && !prev_vb) begin
      cx = int'(xpos_ball);
      cy = int'(ypos_ball);
    end
    prev_vb = vb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, out_bus(), e);
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [11:0] rgb);
    step(tag, h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb);
  endtask

  task automatic vpulse(input int x, input int y);
    xpos_ball = 12'(x);
    ypos_ball = 12'(y);
    step("vbl0", 0, 768, 1'b0, 1'b1, 1'b1, 1'b1, 12'h111);
    step("vbl1", 1, 768, 1'b0, 1'b1, 1'b1, 1'b1, 12'h111);
    step("vbl2", 2, 0,   1'b0, 1'b0, 1'b1, 1'b0, 12'h111);
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) step("flush", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, out_bus(), 40'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n   = 1'b1;
    cx      = 487;
    cy      = 362;
    prev_vb = 1'b0;
    exp_q.delete();
    tag_q.delete();
    // The two stages still holding reset contents must come out as all zero.
    exp_q.push_back(40'h0);
    tag_q.push_back({tag, "_fill0"});
    exp_q.push_back(40'h0);
    tag_q.push_back({tag, "_fill1"});
  endtask

  initial begin
    #12;
    do_reset("reset_init");

    step("latency", 100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0A5);
    step("syncs",   101, 50, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
    step("vblnk",   102, 50, 1'b1, 1'b1, 1'b0, 1'b1, 12'h456);
    step("vb_low",  103, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789);

    // First frame uses the reset centre; no vblnk rising edge has been seen yet
    // (the vblnk step above is one, so re-run the check after a reset below).
    xpos_ball = 12'd300;
    ypos_ball = 12'd300;
    vpulse(300, 300);
    do_reset("reset_mid");
    pix("init_ctr",   487, 362, 12'h0F0);
    pix("init_r",     497, 362, 12'h0F0);
    pix("init_r_out", 498, 362, 12'h0F0);
    pix("init_top",   487, 352, 12'h0F0);
    pix("init_t_out", 487, 351, 12'h0F0);

    vpulse(500, 400);
    pix("edge_x",      510, 400, 12'h00F);
    pix("edge_diag",   506, 408, 12'h00F);
    pix("out_x",       511, 400, 12'h00F);
    pix("out_diag",    508, 407, 12'h00F);
    pix("centre",      500, 400, 12'h00F);
    step("hblnk_ctr",  500, 400, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0C3);

    xpos_ball = 12'd600;
    pix("midframe_500", 500, 400, 12'h0AA);
    pix("midframe_600", 600, 400, 12'h0AA);
    vpulse(600, 400);
    pix("newframe_600", 600, 400, 12'h0AA);
    pix("newframe_500", 500, 400, 12'h0AA);

    vpulse(500, 400);
    for (int i = 0; i < 150; i++) begin
      step("rand", 485 + $urandom_range(0, 30), 385 + $urandom_range(0, 30), 1'b0, 1'b0,
           ($urandom_range(0, 9) == 0), 1'b0, 12'($urandom_range(0, 4095)) & 12'h0FF);
    end

    vpulse(5, 5);
    pix("corner_00",  0, 0,  12'h050);
    pix("corner_013", 0, 13, 12'h050);
    pix("corner_014", 0, 14, 12'h050);
    pix("right_edge", 1023, 5, 12'h050);
    step("wrap_blank", 4090, 5, 1'b0, 1'b0, 1'b1, 1'b0, 12'h050);
    pix("wrap_4095",  4095, 5, 12'h050);
    pix("wrap_4092",  4092, 0, 12'h050);

    do_reset("reset_late");
    pix("late_ctr",  487, 362, 12'h00C);
    pix("late_old",  5, 5, 12'h00C);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
